cmp_search_ctrl: RTL and testbench

- Sequential initiator for the team's combinational magnitude comparator (ports g/e/l).
- Comparator data1 is tied to an unknown target and data2 to this block's probe output.
- The block binary-searches the probe until the comparator reports equal, then returns the target value and the number of probes used.
- The comparator is the responder; this block drives the search.

---
 rtl/cmp_search_ctrl.sv | 177 +++++++++++++++++
 tb/tb_cmp_search_ctrl.sv | 283 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cmp_search_ctrl.sv
// cmp_search_ctrl: binary-search initiator for the g/e/l magnitude comparator.
// The comparator compares an unknown target (data1) against probe (data2).
// This block narrows [lo, hi] until the comparator reports equal. It then
// returns the target value and the number of probes that were issued.
// An inconsistent comparator response ends the search with err set.
module cmp_search_ctrl #(
  parameter int WIDTH = 4,
  parameter int LAT   = 0
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         start,
  input  logic                         cmp_g,
  input  logic                         cmp_e,
  input  logic                         cmp_l,
  output logic [WIDTH-1:0]             probe,
  output logic                         busy,
  output logic                         done,
  output logic                         found,
  output logic                         err,
  output logic [WIDTH-1:0]             result,
  output logic [$clog2(WIDTH+2)-1:0]   steps
);

  localparam int SW = $clog2(WIDTH+2);
  // The settle counter only has to reach LAT-1. Keep it at least one bit wide.
  localparam int CW = (LAT > 1) ? $clog2(LAT) : 1;

  localparam logic [CW-1:0]    CNT_LAST   = CW'((LAT > 0) ? LAT - 1 : 0);
  localparam logic [CW-1:0]    CNT_ONE    = CW'(1);
  localparam logic [SW-1:0]    STEP_ONE   = SW'(1);
  localparam logic [WIDTH-1:0] ONE        = WIDTH'(1);
  localparam logic [WIDTH-1:0] FIRST_PRB  = {1'b0, {(WIDTH-1){1'b1}}};

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // After a new probe is issued, either wait for the comparator to settle or
  // sample it in the very next cycle.
  localparam state_t PROBE_ST = (LAT > 0) ? SETTLE : SAMPLE;

  state_t             state_q;
  logic [WIDTH-1:0]   lo_q, hi_q, probe_q, result_q;
  logic [CW-1:0]      cnt_q;
  logic [SW-1:0]      steps_q;
  logic               busy_q, done_q, found_q, err_q;

  logic [WIDTH-1:0]   up_lo_d, up_probe_d, dn_hi_d, dn_probe_d;
  logic [2:0]         flags;
  logic               flags_ok;

  // Midpoint of [a, b]. Callers guarantee a <= b, so the difference never wraps.
  function automatic logic [WIDTH-1:0] mid(input logic [WIDTH-1:0] a,
                                           input logic [WIDTH-1:0] b);
    return a + ((b - a) >> 1);
  endfunction

  // Candidate bounds and probes for both search directions. They are only
  // consumed when the matching flag is seen and the range is not exhausted.
  always_comb begin
    up_lo_d    = probe_q + ONE;
    up_probe_d = mid(up_lo_d, hi_q);
    dn_hi_d    = probe_q - ONE;
    dn_probe_d = mid(lo_q, dn_hi_d);
    flags      = {cmp_g, cmp_e, cmp_l};
    flags_ok   = $onehot(flags);
  end

  // Search FSM. All outputs are registered here.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      lo_q     <= '0;
      hi_q     <= '0;
      probe_q  <= '0;
      result_q <= '0;
      cnt_q    <= '0;
      steps_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      found_q  <= 1'b0;
      err_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            lo_q     <= '0;
            hi_q     <= '1;
            probe_q  <= FIRST_PRB;
            steps_q  <= STEP_ONE;
            busy_q   <= 1'b1;
            found_q  <= 1'b0;
            err_q    <= 1'b0;
            result_q <= '0;
            cnt_q    <= '0;
            state_q  <= PROBE_ST;
          end
        end

        SETTLE: begin
          if (cnt_q == CNT_LAST) begin
            cnt_q   <= '0;
            state_q <= SAMPLE;
          end else begin
            cnt_q <= cnt_q + CNT_ONE;
          end
        end

        SAMPLE: begin
          if (!flags_ok) begin
            // Zero or several flags high: the comparator response cannot be trusted.
            err_q   <= 1'b1;
            found_q <= 1'b0;
            done_q  <= 1'b1;
            busy_q  <= 1'b0;
            state_q <= DONE;
          end else if (cmp_e) begin
            result_q <= probe_q;
            found_q  <= 1'b1;
            done_q   <= 1'b1;
            busy_q   <= 1'b0;
            state_q  <= DONE;
          end else if (cmp_g) begin
            if (probe_q == hi_q) begin
              // The target is claimed to lie above the top of the range.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              lo_q    <= up_lo_d;
              probe_q <= up_probe_d;
              steps_q <= steps_q + STEP_ONE;
              cnt_q   <= '0;
              state_q <= PROBE_ST;
            end
          end else begin
            if (probe_q == lo_q) begin
              // The target is claimed to lie below the bottom of the range.
              err_q   <= 1'b1;
              done_q  <= 1'b1;
              busy_q  <= 1'b0;
              state_q <= DONE;
            end else begin
              hi_q    <= dn_hi_d;
              probe_q <= dn_probe_d;
              steps_q <= steps_q + STEP_ONE;
              cnt_q   <= '0;
              state_q <= PROBE_ST;
            end
          end
        end

        DONE: begin
          // The done pulse lasts this single cycle. A start seen here is ignored.
          state_q <= IDLE;
        end

        default: state_q <= IDLE;
      endcase
    end
  end

  assign probe  = probe_q;
  assign busy   = busy_q;
  assign done   = done_q;
  assign found  = found_q;
  assign err    = err_q;
  assign result = result_q;
  assign steps  = steps_q;

endmodule

// File: tb/tb_cmp_search_ctrl.sv
// Testbench for cmp_search_ctrl. One instance uses LAT=0 (index 0) and one
// uses LAT=2 (index 1). Each instance is driven by a behavioural comparator.
module tb_cmp_search_ctrl;
  localparam int W = 4;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [1:0]   start_v = '0;
  logic [1:0]   cmp_g, cmp_e, cmp_l, busy_v, done_v, found_v, err_v;
  logic [W-1:0] probe_v [2];
  logic [W-1:0] result_v[2];
  logic [2:0]   steps_v [2];
  logic [W-1:0] tgt_a   [2];
  int           mode_a  [2];   // 0 honest, 1 g and l both high, 2 g stuck high

  int vectors = 0, miscompares = 0;
  int exp_probes[$], exp_cyc[$], obs_seq[$];
  int done_at, busy_bad;

  initial begin
    tgt_a[0] = '0; tgt_a[1] = '0; mode_a[0] = 0; mode_a[1] = 0;
  end

  for (genvar i = 0; i < 2; i++) begin : g_cmp
    assign cmp_g[i] = (mode_a[i] == 0) ? (tgt_a[i] > probe_v[i]) : 1'b1;
    assign cmp_e[i] = (mode_a[i] == 0) && (tgt_a[i] == probe_v[i]);
    assign cmp_l[i] = (mode_a[i] == 0) ? (tgt_a[i] < probe_v[i]) : (mode_a[i] == 1);
  end

  cmp_search_ctrl #(.WIDTH(W), .LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start_v[0]),
    .cmp_g(cmp_g[0]), .cmp_e(cmp_e[0]), .cmp_l(cmp_l[0]),
    .probe(probe_v[0]), .busy(busy_v[0]), .done(done_v[0]), .found(found_v[0]),
    .err(err_v[0]), .result(result_v[0]), .steps(steps_v[0]));

  cmp_search_ctrl #(.WIDTH(W), .LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start_v[1]),
    .cmp_g(cmp_g[1]), .cmp_e(cmp_e[1]), .cmp_l(cmp_l[1]),
    .probe(probe_v[1]), .busy(busy_v[1]), .done(done_v[1]), .found(found_v[1]),
    .err(err_v[1]), .result(result_v[1]), .steps(steps_v[1]));

  // Reference: halve the integer interval [lo, hi] until the target is hit.
  // Each probe is visible for lat+1 cycles.
  function automatic void build_exp(input int tgt, input int lat);
    int lo = 0, hi = (1 << W) - 1, p;
    exp_probes.delete(); exp_cyc.delete();
    for (int n = 0; n < 20; n++) begin
      p = (lo + hi) / 2;
      exp_probes.push_back(p);
      if (p == tgt) break;
      if (tgt > p) lo = p + 1; else hi = p - 1;
    end
    foreach (exp_probes[k]) for (int r = 0; r <= lat; r++) exp_cyc.push_back(exp_probes[k]);
  endfunction

  function automatic bit seq_match();
    if (obs_seq.size() != exp_cyc.size()) return 1'b0;
    foreach (obs_seq[k]) if (obs_seq[k] != exp_cyc[k]) return 1'b0;
    return 1'b1;
  endfunction

  function automatic string str_q(input bit want);
    string s = "";
    if (want) foreach (exp_cyc[k]) s = {s, $sformatf("%0d ", exp_cyc[k])};
    else      foreach (obs_seq[k]) s = {s, $sformatf("%0d ", obs_seq[k])};
    return s;
  endfunction

  // Starts one search on instance s and records the probe seen in every busy cycle.
  // Returns at the negedge of the cycle in which done is high. done_at=-1 on timeout.
  // When pulse_at >= 0, start is raised again in that busy cycle.
  task automatic run(input int s, input int tgt, input int mode, input int pulse_at);
    tgt_a[s] = W'(tgt); mode_a[s] = mode;
    obs_seq.delete(); done_at = -1; busy_bad = 0;
    @(negedge clk); start_v[s] = 1'b1;
    @(posedge clk); #1 start_v[s] = 1'b0;
    for (int idx = 0; idx < 100; idx++) begin
      @(negedge clk);
      start_v[s] = (idx == pulse_at);
      if (done_v[s]) begin
        done_at = idx;
        if (busy_v[s]) busy_bad++;
        break;
      end
      if (!busy_v[s]) busy_bad++;
      obs_seq.push_back(int'(probe_v[s]));
    end
    start_v[s] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      vectors++;
      if ({probe_v[s], busy_v[s], done_v[s], found_v[s], err_v[s], result_v[s], steps_v[s]} !== '0) begin
        miscompares++;
        $display("FAIL reset_state[%0d]: got probe=%0d busy=%b done=%b found=%b err=%b result=%0d steps=%0d, want all 0",
                 s, probe_v[s], busy_v[s], done_v[s], found_v[s], err_v[s], result_v[s], steps_v[s]);
      end
    end
    rst = 1'b0;
  endtask

  task automatic test_hit_first();
    build_exp(7, 0); run(0, 7, 0, -1);
    vectors++;
    if (!seq_match()) begin miscompares++; $display("FAIL hit7_seq: got %s want %s", str_q(0), str_q(1)); end
    vectors++;
    if (done_at !== 1) begin miscompares++; $display("FAIL hit7_done_at: got %0d want 1", done_at); end
    vectors++;
    if ({found_v[0], err_v[0], result_v[0], steps_v[0]} !== {1'b1, 1'b0, 4'd7, 3'd1}) begin
      miscompares++;
      $display("FAIL hit7_status: got found=%b err=%b result=%0d steps=%0d want 1 0 7 1",
               found_v[0], err_v[0], result_v[0], steps_v[0]);
    end
    vectors++;
    if (busy_bad !== 0) begin miscompares++; $display("FAIL hit7_busy: got %0d bad cycles want 0", busy_bad); end
    @(negedge clk);
    vectors++;
    if ({done_v[0], busy_v[0], found_v[0], result_v[0], steps_v[0]} !== {1'b0, 1'b0, 1'b1, 4'd7, 3'd1}) begin
      miscompares++;
      $display("FAIL hit7_hold: got done=%b busy=%b found=%b result=%0d steps=%0d want 0 0 1 7 1",
               done_v[0], busy_v[0], found_v[0], result_v[0], steps_v[0]);
    end
  endtask

  task automatic test_extremes();
    int t;
    for (int k = 0; k < 2; k++) begin
      t = (k == 0) ? 0 : 15;
      build_exp(t, 0); run(0, t, 0, -1);
      vectors++;
      if (!seq_match()) begin miscompares++; $display("FAIL edge%0d_seq: got %s want %s", t, str_q(0), str_q(1)); end
      vectors++;
      if (done_at !== ((k == 0) ? 4 : 5)) begin
        miscompares++; $display("FAIL edge%0d_done_at: got %0d want %0d", t, done_at, (k == 0) ? 4 : 5);
      end
      vectors++;
      if ({found_v[0], err_v[0], result_v[0], steps_v[0]} !== {1'b1, 1'b0, 4'(t), 3'((k == 0) ? 4 : 5)}) begin
        miscompares++;
        $display("FAIL edge%0d_status: got found=%b err=%b result=%0d steps=%0d", t,
                 found_v[0], err_v[0], result_v[0], steps_v[0]);
      end
    end
  endtask

  task automatic test_sweep();
    for (int t = 0; t < 16; t++) begin
      build_exp(t, 0); run(0, t, 0, -1);
      vectors++;
      if (!seq_match() || done_at != exp_probes.size() || busy_bad != 0) begin
        miscompares++;
        $display("FAIL sweep%0d_seq: got %s done_at=%0d want %s done_at=%0d", t, str_q(0), done_at,
                 str_q(1), exp_probes.size());
      end
      vectors++;
      if ({found_v[0], err_v[0], result_v[0], steps_v[0]} !== {1'b1, 1'b0, 4'(t), 3'(exp_probes.size())}
          || steps_v[0] > 3'd5) begin
        miscompares++;
        $display("FAIL sweep%0d_status: got found=%b err=%b result=%0d steps=%0d want steps=%0d", t,
                 found_v[0], err_v[0], result_v[0], steps_v[0], exp_probes.size());
      end
    end
  endtask

  task automatic test_lat2();
    int t;
    for (int k = 0; k < 7; k++) begin
      t = (k == 0) ? 12 : int'($urandom_range(0, 15));
      build_exp(t, 2); run(1, t, 0, -1);
      vectors++;
      if (!seq_match()) begin miscompares++; $display("FAIL lat2_t%0d_seq: got %s want %s", t, str_q(0), str_q(1)); end
      vectors++;
      if (done_at !== 3 * exp_probes.size()) begin
        miscompares++; $display("FAIL lat2_t%0d_done_at: got %0d want %0d", t, done_at, 3 * exp_probes.size());
      end
      vectors++;
      if ({found_v[1], err_v[1], result_v[1], steps_v[1]} !== {1'b1, 1'b0, 4'(t), 3'(exp_probes.size())}) begin
        miscompares++;
        $display("FAIL lat2_t%0d_status: got found=%b err=%b result=%0d steps=%0d", t,
                 found_v[1], err_v[1], result_v[1], steps_v[1]);
      end
    end
  endtask

  task automatic test_faults();
    run(0, 5, 1, -1);
    vectors++;
    if (done_at !== 1 || {found_v[0], err_v[0], result_v[0], steps_v[0]} !== {1'b1 ^ 1'b1, 1'b1, 4'd0, 3'd1}) begin
      miscompares++;
      $display("FAIL fault_both: got done_at=%0d found=%b err=%b result=%0d steps=%0d want 1 0 1 0 1",
               done_at, found_v[0], err_v[0], result_v[0], steps_v[0]);
    end
    // g stuck high: the search climbs to the top of the range, then reports exhaustion.
    build_exp(15, 0); run(0, 5, 2, -1);
    vectors++;
    if (!seq_match() || done_at !== 5) begin
      miscompares++; $display("FAIL fault_g_seq: got %s done_at=%0d want %s done_at=5", str_q(0), done_at, str_q(1));
    end
    vectors++;
    if ({found_v[0], err_v[0], result_v[0], steps_v[0]} !== {1'b0, 1'b1, 4'd0, 3'd5}) begin
      miscompares++;
      $display("FAIL fault_g_status: got found=%b err=%b result=%0d steps=%0d want 0 1 0 5",
               found_v[0], err_v[0], result_v[0], steps_v[0]);
    end
  endtask

  task automatic test_mid_reset();
    bit saw_done = 1'b0;
    tgt_a[0] = 4'd15; mode_a[0] = 0;
    @(negedge clk); start_v[0] = 1'b1;
    @(posedge clk); #1 start_v[0] = 1'b0;
    @(negedge clk); saw_done |= done_v[0];
    @(negedge clk); saw_done |= done_v[0];
    vectors++;
    if (probe_v[0] !== 4'd11) begin miscompares++; $display("FAIL midrst_pre: got probe=%0d want 11", probe_v[0]); end
    #2 rst = 1'b1;
    #1;
    vectors++;
    if ({probe_v[0], busy_v[0], done_v[0], found_v[0], err_v[0], result_v[0], steps_v[0]} !== '0 || saw_done) begin
      miscompares++;
      $display("FAIL midrst_clear: got probe=%0d busy=%b done=%b found=%b err=%b result=%0d steps=%0d earlier_done=%b",
               probe_v[0], busy_v[0], done_v[0], found_v[0], err_v[0], result_v[0], steps_v[0], saw_done);
    end
    for (int c = 0; c < 3; c++) begin @(negedge clk); saw_done |= done_v[0] | busy_v[0]; end
    vectors++;
    if (saw_done) begin miscompares++; $display("FAIL midrst_quiet: got done/busy activity during reset, want none"); end
    rst = 1'b0;
    build_exp(9, 0); run(0, 9, 0, -1);
    vectors++;
    if (!seq_match() || result_v[0] !== 4'd9) begin
      miscompares++; $display("FAIL midrst_restart: got %s result=%0d want %s result=9", str_q(0), result_v[0], str_q(1));
    end
  endtask

  task automatic test_start_while_busy();
    int t, p;
    for (int k = 0; k < 6; k++) begin
      t = (k == 0) ? 0 : int'($urandom_range(0, 15));
      p = (k == 0) ? 2 : int'($urandom_range(0, 3));
      build_exp(t, 0); run(0, t, 0, p);
      vectors++;
      if (!seq_match() || done_at != exp_probes.size() || result_v[0] !== 4'(t) || steps_v[0] !== 3'(exp_probes.size())) begin
        miscompares++;
        $display("FAIL busystart_t%0d_p%0d: got %s done_at=%0d result=%0d steps=%0d want %s", t, p, str_q(0),
                 done_at, result_v[0], steps_v[0], str_q(1));
      end
    end
  endtask

  task automatic test_start_in_done();
    run(0, 3, 0, -1);
    start_v[0] = 1'b1;               // held over the done cycle's closing edge
    @(negedge clk); start_v[0] = 1'b0;
    vectors++;
    if (busy_v[0] !== 1'b0 || done_v[0] !== 1'b0) begin
      miscompares++; $display("FAIL donestart_a: got busy=%b done=%b want 0 0", busy_v[0], done_v[0]);
    end
    @(negedge clk);
    vectors++;
    if (busy_v[0] !== 1'b0 || result_v[0] !== 4'd3 || found_v[0] !== 1'b1) begin
      miscompares++;
      $display("FAIL donestart_b: got busy=%b result=%0d found=%b want 0 3 1", busy_v[0], result_v[0], found_v[0]);
    end
  endtask

  initial begin
    test_reset();
    test_hit_first();
    test_extremes();
    test_sweep();
    test_lat2();
    test_faults();
    test_sweep();
    test_mid_reset();
    test_start_while_busy();
    test_start_in_done();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
